seq_mul_su: RTL and testbench
=============================

// Module: seq_mul_su
// PURPOSE
//  Iterative radix-4 multiplier: signed (or unsigned, per-op mode) s times unsigned u, W-bit operands, exact 2W-bit product.
//  Each cycle retires one 2-bit digit of u via a row generator; the running sum is kept in an accumulator.
//  Valid/ready on both sides; sits in datapaths where a full-array multiplier is too large and a few cycles of latency are acceptable.
// PARAMETERS
//  W           4   operand width; even, >= 4
//  EARLY_TERM  0   1: finish as soon as the remaining u digits are all zero; 0: fixed latency
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous reset, active-high
//  in_valid   in   1    operands valid
//  in_ready   out  1    block can accept operands (high only in IDLE)
//  s          in   W    multiplicand
//  u          in   W    multiplier, always unsigned
//  s_signed   in   1    1: s is two's complement; 0: s is unsigned
//  abort      in   1    synchronous cancel of the current operation
//  out_valid  out  1    product valid
//  out_ready  in   1    consumer accepts product
//  product    out  2W   exact product; two's complement when s_signed=1
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, acc=0, product=0, out_valid=0, busy=0, digit count=0. in_ready=1 once rst is released.
//  States:
//   IDLE  in_ready=1. On in_valid: latch s, u, s_signed; acc=0; cnt=0; go to RUN.
//   RUN   each edge: acc += (ext(s)*d) << 2*cnt, where d=u[2cnt+1:2cnt] in 0..3; cnt++.
//         ext(s) is sign-extended when s_signed=1, zero-extended otherwise, to 2W bits. Arithmetic is mod 2^2W, which is exact for all inputs.
//         Leave RUN after the edge that processes digit W/2-1 (EARLY_TERM=0), or earlier when all higher u digits are 0 (EARLY_TERM=1).
//         On that edge: product<=final acc, out_valid<=1, go to DONE.
//   DONE  product and out_valid are held stable until out_ready=1. On the handshake edge: out_valid<=0, go to IDLE.
//  Latency: out_valid rises exactly W/2 edges after the accepting edge when EARLY_TERM=0.
//   With EARLY_TERM=1 it is 1..W/2 edges; u=0 or u<4 takes 1 edge.
//  Throughput: one op per (latency+2) cycles minimum. No accept in the DONE-exit cycle.
//  abort:
//   In RUN: return to IDLE next edge, discarding acc; out_valid stays 0.
//   In DONE: ignored; the result must drain.
//   In IDLE: ignored. abort has priority over in_valid in the same cycle (no accept).
//  Operand inputs are sampled only at the accept edge; later changes have no effect.
//  out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored; the producer must hold it.
//  Reset mid-operation: immediate return to reset values; no partial product is ever presented.
//  Corner values (W=4): s=-8, u=15 -> -120. Unsigned s=15, u=15 -> 225. Neither overflows.
// STRUCTURE
//  Package seq_mul_pkg:
//   state enum {IDLE, RUN, DONE}
//   function clog2
//   localparam-style function DIGITS(W)=W/2
//  Sub-module mul_row_su:
//   combinational s*d for d in 0..3, with a s_signed input
//   2W-bit output built from the 2-bit signed/unsigned sub-products (0, s, 2s, 3s=2s+s)
//  Top holds:
//   FSM
//   cnt of width clog2(W/2)+1
//   u shift register (>>2 per RUN edge; EARLY_TERM tests its upper bits == 0)
//   2W-bit accumulator and product register
// TESTING
//  W=4, signed, s=4'h8 (-8), u=4'hF -> product=8'h88 (-120), out_valid exactly 2 edges after accept.
//  W=4, unsigned, s=4'hF, u=4'hF -> 8'hE1 (225). Signed s=4'hF (-1), u=1 -> 8'hFF.
//  out_ready held 0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0; release -> in_ready=1 the next cycle.
//  abort on first RUN cycle with s=7, u=9 -> IDLE, out_valid never rises. The next op s=3, u=5 -> 8'h0F.
//  W=8, EARLY_TERM=1, s=8'h80, u=8'h01 -> 16'hFF80 after 1 edge. Same with u=8'hC0 -> 16'hA000 after 4 edges.
//  W=4 and W=8, both EARLY_TERM values, exhaustive s, u, mode with random backpressure and async rst pulses -> matches reference model.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared types and elaboration helpers for the iterative radix-4 multiplier.
//   state_t : controller states (IDLE, RUN, DONE)
//   clog2   : ceiling log2, used to size the digit counter
//   digits  : number of 2-bit multiplier digits for a W-bit operand
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned digits(input int unsigned w);
    return w / 2;
  endfunction

endpackage

// File: rtl/mul_row_su.sv
// Radix-4 row generator: multiplies the multiplicand by one unsigned 2-bit
// digit and returns the result extended to 2W bits.
//   s        : multiplicand, W bits
//   s_signed : 1 = s is two's complement, 0 = s is unsigned
//   d        : multiplier digit, 0..3
//   row      : s*d, 2W bits (mod 2^2W)
module mul_row_su #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0]   s,
  input  logic           s_signed,
  input  logic [1:0]     d,
  output logic [2*W-1:0] row
);

  logic [2*W-1:0] s1;
  logic [2*W-1:0] s2;
  logic [2*W-1:0] s3;

  always_comb begin
    s1 = {{W{s_signed & s[W-1]}}, s};
    s2 = s1 << 1;
    s3 = s2 + s1;
    case (d)
      2'd0:    row = '0;
      2'd1:    row = s1;
      2'd2:    row = s2;
      default: row = s3;
    endcase
  end

endmodule

// File: rtl/seq_mul_su.sv
// Iterative radix-4 multiplier: (signed or unsigned) s times unsigned u,
// exact 2W-bit product, one multiplier digit retired per RUN cycle.
//   clk, rst             : clock (rising edge), async active-high reset
//   in_valid / in_ready  : operand handshake (accept only in IDLE)
//   s, u, s_signed       : operands and per-op signedness of s
//   abort                : cancels an operation in RUN
//   out_valid / out_ready: product handshake (held in DONE until taken)
//   product              : 2W-bit result
//   busy                 : controller not in IDLE
module seq_mul_su
  import seq_mul_pkg::*;
#(
  parameter int unsigned W          = 4,
  parameter int unsigned EARLY_TERM = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   s,
  input  logic [W-1:0]   u,
  input  logic           s_signed,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int unsigned NDIG = digits(W);
  localparam int unsigned CW   = clog2(NDIG) + 1;

  state_t         state;
  state_t         state_next;

  logic [W-1:0]   s_reg;
  logic           s_signed_reg;
  logic [W-1:0]   u_sh;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic [2*W-1:0] row;
  logic [CW:0]    shamt;
  logic [2*W-1:0] acc_next;
  logic           last_digit;

  logic           accept;
  logic           step;
  logic           finish;
  logic           drain;

  mul_row_su #(.W(W)) u_row (
    .s        (s_reg),
    .s_signed (s_signed_reg),
    .d        (u_sh[1:0]),
    .row      (row)
  );

  // u_sh is shifted right each step, so the current digit is always in bits
  // [1:0] and the still-unprocessed digits sit in [W-1:2].
  always_comb begin
    shamt      = {cnt, 1'b0};
    acc_next   = acc + (row << shamt);
    last_digit = (cnt == CW'(NDIG - 1)) ||
                 ((EARLY_TERM != 0) && (u_sh[W-1:2] == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    drain      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && !abort) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (last_digit) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          drain      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg        <= '0;
      s_signed_reg <= 1'b0;
      u_sh         <= '0;
      acc          <= '0;
      cnt          <= '0;
      product      <= '0;
      out_valid    <= 1'b0;
    end else begin
      if (accept) begin
        s_reg        <= s;
        s_signed_reg <= s_signed;
        u_sh         <= u;
        acc          <= '0;
        cnt          <= '0;
      end
      if (step) begin
        acc  <= acc_next;
        cnt  <= cnt + CW'(1);
        u_sh <= u_sh >> 2;
      end
      if (finish) begin
        product   <= acc_next;
        out_valid <= 1'b1;
      end
      if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

  // in_ready is gated by rst so no handshake completes while reset is held.
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_seq_mul_su.sv
module tb_seq_mul_su;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Four instances: g0 W=4 fixed, g1 W=4 early, g2 W=8 fixed, g3 W=8 early.
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [3:0][7:0]  s_v;
  logic [3:0][7:0]  u_v;
  logic [3:0]       s_sg;
  logic [3:0]       abort_v;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [3:0][15:0] prod_v;
  logic [3:0]       busy_v;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned GW = (g < 2) ? 4 : 8;
    logic [2*GW-1:0] p;
    seq_mul_su #(.W(GW), .EARLY_TERM(g % 2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .s         (s_v[g][GW-1:0]),
      .u         (u_v[g][GW-1:0]),
      .s_signed  (s_sg[g]),
      .abort     (abort_v[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .product   (p),
      .busy      (busy_v[g])
    );
    assign prod_v[g] = 16'(p);
  end

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int w_of(input int g);
    return (g < 2) ? 4 : 8;
  endfunction

  // Reference: plain integer multiply of the interpreted operands, reduced to 2W bits.
  function automatic logic [15:0] model(input int g, input logic [7:0] s, input logic [7:0] u, input bit sg);
    int     w;
    longint one, sv, uv, p;
    w   = w_of(g);
    one = 1;
    sv  = longint'({56'b0, s}) & ((one << w) - 1);
    uv  = longint'({56'b0, u}) & ((one << w) - 1);
    if (sg && sv >= (one << (w - 1))) sv = sv - (one << w);
    p = sv * uv;
    return 16'(p & ((one << (2 * w)) - 1));
  endfunction

  // Latency: all W/2 digits when fixed, else up to the highest nonzero digit (min 1).
  function automatic int exp_lat(input int g, input logic [7:0] u);
    int w, lat;
    w = w_of(g);
    if (g % 2 == 0) return w / 2;
    lat = 1;
    for (int i = 1; i < w / 2; i++) begin
      if ((u >> (2 * i)) != 8'd0) lat = i + 1;
    end
    return lat;
  endfunction

  // All tasks start and end at a negedge.
  task automatic accept_op(input int g, input logic [7:0] s, input logic [7:0] u, input bit sg);
    int n;
    n = 0;
    while (!in_ready[g] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 32'(in_ready[g]), 32'd1);
    in_valid[g] = 1'b1;
    s_v[g]      = s;
    u_v[g]      = u;
    s_sg[g]     = sg;
    @(negedge clk);
    in_valid[g] = 1'b0;
    s_v[g]      = 8'($urandom);
    u_v[g]      = 8'($urandom);
    s_sg[g]     = 1'($urandom);
    check("busy_after_accept", 32'(busy_v[g]), 32'd1);
  endtask

  task automatic do_op(input int g, input logic [7:0] s, input logic [7:0] u, input bit sg,
                       input logic [15:0] ep, input int el, input int bp, input bit ab_done);
    int          n;
    bit          seen;
    logic [15:0] held;
    accept_op(g, s, u, sg);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 8) begin
      out_ready[g] = 1'($urandom);
      @(negedge clk);
      n++;
      seen = out_valid[g];
    end
    out_ready[g] = 1'b0;
    check("latency", 32'(n), 32'(el));
    check("product", 32'(prod_v[g]), 32'(ep));
    held = prod_v[g];
    for (int i = 0; i < bp; i++) begin
      abort_v[g] = ab_done;
      @(negedge clk);
      check("hold_valid", 32'(out_valid[g]), 32'd1);
      check("hold_product", 32'(prod_v[g]), 32'(held));
      check("hold_in_ready", 32'(in_ready[g]), 32'd0);
    end
    abort_v[g]   = 1'b0;
    out_ready[g] = 1'b1;
    @(negedge clk);
    out_ready[g] = 1'b0;
    check("drain_valid", 32'(out_valid[g]), 32'd0);
    check("drain_in_ready", 32'(in_ready[g]), 32'd1);
  endtask

  task automatic abort_op(input int g, input logic [7:0] s, input logic [7:0] u, input bit sg, input int k);
    bit rose;
    accept_op(g, s, u, sg);
    for (int i = 0; i < k; i++) begin
      out_ready[g] = 1'($urandom);
      @(negedge clk);
    end
    out_ready[g] = 1'b0;
    abort_v[g]   = 1'b1;
    @(negedge clk);
    abort_v[g] = 1'b0;
    check("abort_busy", 32'(busy_v[g]), 32'd0);
    check("abort_in_ready", 32'(in_ready[g]), 32'd1);
    rose = out_valid[g];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rose = rose | out_valid[g];
    end
    check("abort_no_valid", 32'(rose), 32'd0);
  endtask

  task automatic reset_op(input int g, input logic [7:0] s, input logic [7:0] u, input bit sg, input int k);
    accept_op(g, s, u, sg);
    for (int i = 0; i < k; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_product", 32'(prod_v[g]), 32'd0);
    check("rst_valid", 32'(out_valid[g]), 32'd0);
    check("rst_busy", 32'(busy_v[g]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready[g]), 32'd1);
  endtask

  typedef struct {
    int          g;
    logic [7:0]  s;
    logic [7:0]  u;
    bit          sg;
    logic [15:0] ep;
    int          el;
    int          bp;
  } vec_t;

  task automatic random_op(input int g, input logic [7:0] s, input logic [7:0] u, input bit sg);
    int r, el, bp;
    el = exp_lat(g, u);
    r  = int'($urandom_range(0, 19));
    if (r == 0)      abort_op(g, s, u, sg, int'($urandom_range(0, el - 1)));
    else if (r == 1) reset_op(g, s, u, sg, int'($urandom_range(0, el + 1)));
    bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    do_op(g, s, u, sg, model(g, s, u, sg), el, bp, 1'($urandom));
  endtask

  vec_t vt[$];

  initial begin
    in_valid  = '0;
    abort_v   = '0;
    out_ready = '0;
    s_v       = '0;
    u_v       = '0;
    s_sg      = '0;

    #1 rst = 1'b1;
    #2;
    check("reset_product", 32'(prod_v), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy_v), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'hF);

    vt.push_back('{0, 8'h08, 8'h0F, 1'b1, 16'h0088, 2, 0});
    vt.push_back('{0, 8'h0F, 8'h0F, 1'b0, 16'h00E1, 2, 5});
    vt.push_back('{0, 8'h0F, 8'h01, 1'b1, 16'h00FF, 2, 0});
    vt.push_back('{1, 8'h08, 8'h0F, 1'b1, 16'h0088, 2, 1});
    vt.push_back('{1, 8'h07, 8'h00, 1'b1, 16'h0000, 1, 0});
    vt.push_back('{1, 8'h05, 8'h03, 1'b0, 16'h000F, 1, 0});
    vt.push_back('{2, 8'h80, 8'h01, 1'b1, 16'hFF80, 4, 0});
    vt.push_back('{2, 8'h80, 8'hFF, 1'b1, 16'h8080, 4, 2});
    vt.push_back('{3, 8'h80, 8'h01, 1'b1, 16'hFF80, 1, 0});
    vt.push_back('{3, 8'h80, 8'hC0, 1'b1, 16'hA000, 4, 0});
    vt.push_back('{3, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 4, 1});
    vt.push_back('{3, 8'h7F, 8'h05, 1'b1, 16'h027B, 2, 0});
    foreach (vt[i]) do_op(vt[i].g, vt[i].s, vt[i].u, vt[i].sg, vt[i].ep, vt[i].el, vt[i].bp, 1'b0);

    // Abort on the first RUN cycle, then a normal op must be unaffected.
    abort_op(0, 8'h07, 8'h09, 1'b0, 0);
    do_op(0, 8'h03, 8'h05, 1'b0, 16'h000F, 2, 0, 1'b0);

    // abort wins over in_valid in IDLE: nothing is accepted.
    in_valid[0] = 1'b1;
    abort_v[0]  = 1'b1;
    s_v[0]      = 8'h05;
    u_v[0]      = 8'h05;
    @(negedge clk);
    check("idle_abort_no_accept", 32'(busy_v[0]), 32'd0);
    in_valid[0] = 1'b0;
    abort_v[0]  = 1'b0;
    @(negedge clk);

    // abort while the result waits in DONE is ignored.
    do_op(0, 8'h08, 8'h0F, 1'b1, 16'h0088, 2, 3, 1'b1);

    for (int g = 0; g < 2; g++) begin
      for (int s = 0; s < 16; s++) begin
        for (int u = 0; u < 16; u++) begin
          for (int m = 0; m < 2; m++) begin
            random_op(g, 8'(s), 8'(u), 1'(m));
          end
        end
      end
    end

    for (int g = 2; g < 4; g++) begin
      for (int i = 0; i < 600; i++) begin
        logic [7:0] s, u;
        s = 8'($urandom);
        u = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        random_op(g, s, u, 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
